// File: rtl/instru_mem_writer_pkg.sv
// Shared Y86-64 encoding constants, FSM state type and the byte-image encoder
// used by the instruction memory writer.
package instru_mem_writer_pkg;

   localparam int DATA_WID = 64;
   localparam int ENC_WID  = 80;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_NOP    = 4'h1;
   localparam logic [3:0] I_RRMOVQ = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;
   localparam logic [3:0] RNONE    = 4'hF;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } state_t;

   // Byte 0 sits in bits [7:0]; bytes are emitted from the low end upward.
   function automatic logic [ENC_WID-1:0] encode(
      input logic [3:0]          icode,
      input logic [3:0]          ifun,
      input logic [3:0]          ra,
      input logic [3:0]          rb,
      input logic [DATA_WID-1:0] valc,
      input logic                has_reg
   );
      if (has_reg)
         encode = {valc, ra, rb, icode, ifun};
      else
         encode = {8'h00, valc, icode, ifun};
   endfunction

endpackage

// File: rtl/instru_mem_writer_len.sv
// instru_len: combinational icode -> encoded length, legality and
// register-byte presence. Shared with the fetch-side PC increment.
import instru_mem_writer_pkg::*;

module instru_len (
   input  logic [3:0] icode,
   output logic [3:0] len,
   output logic       legal,
   output logic       has_reg
);

   // Length table; icodes C..F are illegal and report len 0.
   always_comb begin
      len     = 4'd0;
      legal   = 1'b1;
      has_reg = 1'b0;
      case (icode)
         I_HALT, I_NOP, I_RET:                len = 4'd1;
         I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
            len     = 4'd2;
            has_reg = 1'b1;
         end
         I_JXX, I_CALL:                       len = 4'd9;
         I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
            len     = 4'd10;
            has_reg = 1'b1;
         end
         default:                             legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instru_mem_writer.sv
// instru_mem_writer: encodes one Y86-64 instruction tuple per handshake and
// writes it byte-serially, little-endian, into byte-wide instruction memory.
// Optional build macro INSTRU_WRITER_RNONE_EN forces unused register nibbles
// (rA of irmovq, rB of pushq/popq) to RNONE.
//
// state  | meaning
// S_IDLE | ready for a tuple; restart and rejection handled here
// S_EMIT | one byte written per cycle, rem counts bytes still to go
import instru_mem_writer_pkg::*;

module instru_mem_writer #(
   parameter int ADDR_WID  = 11,
   parameter int BASE_ADDR = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                restart,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          icode,
   input  logic [3:0]          ifun,
   input  logic [3:0]          rA,
   input  logic [3:0]          rB,
   input  logic [DATA_WID-1:0] valC,
   output logic                wr_en,
   output logic [ADDR_WID-1:0] wr_addr,
   output logic [7:0]          wr_data,
   output logic [ADDR_WID-1:0] wr_ptr,
   output logic                err,
   output logic                err_ovf
);

   localparam logic [ADDR_WID-1:0] BASE  = ADDR_WID'(BASE_ADDR);
   localparam logic [ADDR_WID:0]   LIMIT = (ADDR_WID+1)'(1) << ADDR_WID;

   state_t               state;
   logic [3:0]           rem;
   logic [ENC_WID-9:0]   shreg;

   logic [3:0]           len;
   logic                 legal;
   logic                 has_reg;
   logic [3:0]           ra_eff;
   logic [3:0]           rb_eff;
   logic [ENC_WID-1:0]   enc;
   logic [ADDR_WID:0]    end_sum;

   instru_len u_len (
      .icode   (icode),
      .len     (len),
      .legal   (legal),
      .has_reg (has_reg)
   );

   // Register nibble substitution and byte-image build for the offered tuple.
   always_comb begin
      ra_eff = rA;
      rb_eff = rB;
`ifdef INSTRU_WRITER_RNONE_EN
      if (icode == I_IRMOVQ)
         ra_eff = RNONE;
      if (icode == I_PUSHQ || icode == I_POPQ)
         rb_eff = RNONE;
`endif
      enc     = encode(icode, ifun, ra_eff, rb_eff, valC, has_reg);
      end_sum = {1'b0, wr_ptr} + {{(ADDR_WID-3){1'b0}}, len};
   end

   assign in_ready = (state == S_IDLE) && !restart;

   // Accept/reject in IDLE, then shift the encoded image out one byte per cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         wr_ptr  <= BASE;
         wr_en   <= 1'b0;
         wr_addr <= '0;
         wr_data <= '0;
         err     <= 1'b0;
         err_ovf <= 1'b0;
         rem     <= '0;
         shreg   <= '0;
      end else begin
         err     <= 1'b0;
         err_ovf <= 1'b0;
         case (state)
            S_IDLE: begin
               wr_en <= 1'b0;
               if (restart) begin
                  wr_ptr <= BASE;
               end else if (in_valid) begin
                  if (!legal) begin
                     err     <= 1'b1;
                     err_ovf <= 1'b0;
                  end else if (end_sum > LIMIT) begin
                     err     <= 1'b1;
                     err_ovf <= 1'b1;
                  end else begin
                     state   <= S_EMIT;
                     wr_en   <= 1'b1;
                     wr_addr <= wr_ptr;
                     wr_data <= enc[7:0];
                     shreg   <= enc[ENC_WID-1:8];
                     rem     <= len - 4'd1;
                  end
               end
            end
            S_EMIT: begin
               if (rem == 4'd0) begin
                  // Overflow was excluded at accept, so +1 only truncates on an exact fit.
                  wr_en  <= 1'b0;
                  wr_ptr <= wr_addr + ADDR_WID'(1);
                  state  <= S_IDLE;
               end else begin
                  wr_addr <= wr_addr + ADDR_WID'(1);
                  wr_data <= shreg[7:0];
                  shreg   <= {8'h00, shreg[ENC_WID-9:8]};
                  rem     <= rem - 4'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instru_mem_writer.sv
// Self-checking bench for instru_mem_writer: a scoreboard of expected
// (address, byte) writes is filled when a tuple is accepted and drained by a
// monitor on every wr_en cycle.
module tb_instru_mem_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        restart;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC;
   logic        wr_en;
   logic [10:0] wr_addr;
   logic [7:0]  wr_data;
   logic [10:0] wr_ptr;
   logic        err;
   logic        err_ovf;

   int total = 0;
   int bad   = 0;
   int mptr  = 0;
   logic [18:0] sbq[$];

   instru_mem_writer dut (
      .clk      (clk),
      .rst      (rst),
      .restart  (restart),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .icode    (icode),
      .ifun     (ifun),
      .rA       (rA),
      .rB       (rB),
      .valC     (valC),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .wr_ptr   (wr_ptr),
      .err      (err),
      .err_ovf  (err_ovf)
   );

   always #5 clk = ~clk;

   function automatic int tb_len(input logic [3:0] ic);
      case (ic)
         4'h0, 4'h1, 4'h9:       return 1;
         4'h2, 4'h6, 4'hA, 4'hB: return 2;
         4'h7, 4'h8:             return 9;
         4'h3, 4'h4, 4'h5:       return 10;
         default:                return 0;
      endcase
   endfunction

   function automatic logic [7:0] tb_byte(input logic [3:0] ic, input logic [3:0] f,
                                          input logic [3:0] a, input logic [3:0] b,
                                          input logic [63:0] v, input int k);
      int l;
      bit regb;
      int idx;
      logic [3:0] aa, bb;
      logic [63:0] sh;
      l    = tb_len(ic);
      regb = (l == 2) || (l == 10);
      aa   = a;
      bb   = b;
`ifdef INSTRU_WRITER_RNONE_EN
      if (ic == 4'h3) aa = 4'hF;
      if (ic == 4'hA || ic == 4'hB) bb = 4'hF;
`endif
      if (k == 0) return {ic, f};
      if (regb && k == 1) return {aa, bb};
      idx = regb ? k - 2 : k - 1;
      sh  = v >> (8 * idx);
      return sh[7:0];
   endfunction

   // Monitor: every write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         logic [18:0] exp;
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL write_unexpected got addr=%0d data=%h expected none", wr_addr, wr_data);
         end else begin
            exp = sbq.pop_front();
            if ({wr_addr, wr_data} !== exp) begin
               bad++;
               $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                        wr_addr, wr_data, exp[18:8], exp[7:0]);
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; restart = 1'b0; in_valid = 1'b0;
      icode = 4'h0; ifun = 4'h0; rA = 4'h0; rB = 4'h0; valC = '0;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      mptr = 0;
      sbq.delete();
   endtask

   // Offers one tuple; on return the bench is 1 time unit after the accept edge.
   task automatic send(input logic [3:0] ic, input logic [3:0] f, input logic [3:0] a,
                       input logic [3:0] b, input logic [63:0] v, output int l, output bit ok);
      bit ovf;
      l   = tb_len(ic);
      ovf = (l != 0) && (mptr + l > 2048);
      ok  = (l != 0) && !ovf;
      @(negedge clk);
      icode = ic; ifun = f; rA = a; rB = b; valC = v; in_valid = 1'b1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL send_ready got %b expected 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (ok) begin
         for (int k = 0; k < l; k++)
            sbq.push_back({11'((mptr + k) % 2048), tb_byte(ic, f, a, b, v, k)});
         total++;
         if (wr_en !== 1'b1 || wr_addr !== 11'(mptr)) begin
            bad++;
            $display("FAIL first_write got en=%b addr=%0d expected en=1 addr=%0d", wr_en, wr_addr, mptr);
         end
         mptr = (mptr + l) % 2048;
      end else begin
         total++;
         if (err !== 1'b1 || err_ovf !== ovf || wr_en !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reject got err=%b ovf=%b en=%b rdy=%b expected err=1 ovf=%b en=0 rdy=1",
                     err, err_ovf, wr_en, in_ready, ovf);
         end
         @(posedge clk); #1;
         total++;
         if (err !== 1'b0 || wr_en !== 1'b0 || wr_ptr !== 11'(mptr)) begin
            bad++;
            $display("FAIL reject_after got err=%b en=%b ptr=%0d expected err=0 en=0 ptr=%0d",
                     err, wr_en, wr_ptr, mptr);
         end
      end
   endtask

   task automatic wait_done(input int l);
      int cnt;
      cnt = 1;
      while (in_ready !== 1'b1 && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      total++;
      if (cnt != l + 1) begin
         bad++;
         $display("FAIL done_latency got %0d cycles expected %0d", cnt, l + 1);
      end
      total++;
      if (wr_ptr !== 11'(mptr) || sbq.size() != 0) begin
         bad++;
         $display("FAIL done_state got ptr=%0d pending=%0d expected ptr=%0d pending=0",
                  wr_ptr, sbq.size(), mptr);
      end
   endtask

   task automatic send_full(input logic [3:0] ic, input logic [3:0] f, input logic [3:0] a,
                            input logic [3:0] b, input logic [63:0] v);
      int l;
      bit ok;
      send(ic, f, a, b, v, l, ok);
      if (ok) wait_done(l);
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (in_ready !== 1'b1 || wr_en !== 1'b0 || wr_ptr !== 11'd0 || wr_addr !== 11'd0 ||
          wr_data !== 8'h00 || err !== 1'b0 || err_ovf !== 1'b0) begin
         bad++;
         $display("FAIL reset got rdy=%b en=%b ptr=%0d addr=%0d data=%h err=%b ovf=%b expected 1,0,0,0,00,0,0",
                  in_ready, wr_en, wr_ptr, wr_addr, wr_data, err, err_ovf);
      end
   endtask

   task automatic test_irmovq();
      do_reset();
      send_full(4'h3, 4'h0, 4'hF, 4'h2, 64'h0102030405060708);
      total++;
      if (wr_ptr !== 11'd10) begin
         bad++;
         $display("FAIL irmovq_ptr got %0d expected 10", wr_ptr);
      end
   endtask

   task automatic test_call_after_nop();
      do_reset();
      send_full(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
      send_full(4'h8, 4'h0, 4'h0, 4'h0, 64'h100);
      send_full(4'h9, 4'h0, 4'h0, 4'h0, 64'h0);
      send_full(4'h6, 4'h1, 4'h3, 4'h4, 64'hFFFF);
      send_full(4'h5, 4'h0, 4'h7, 4'h1, 64'hDEADBEEF_CAFEF00D);
   endtask

   task automatic test_illegal();
      do_reset();
      send_full(4'h2, 4'h0, 4'h1, 4'h2, 64'h0);
      for (int ic = 12; ic < 16; ic++)
         send_full(4'(ic), 4'h0, 4'h1, 4'h2, 64'h55);
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 204; i++)
         send_full(4'h3, 4'h0, 4'hF, 4'(i), {$urandom, $urandom});
      total++;
      if (wr_ptr !== 11'd2040) begin
         bad++;
         $display("FAIL fill_ptr got %0d expected 2040", wr_ptr);
      end
      send_full(4'h3, 4'h0, 4'hF, 4'h1, 64'h1234);
      send_full(4'h7, 4'h0, 4'h0, 4'h0, 64'h40);
      send_full(4'h2, 4'h0, 4'h3, 4'h4, 64'h0);
      send_full(4'h2, 4'h0, 4'h5, 4'h6, 64'h0);
      send_full(4'hA, 4'h0, 4'h7, 4'h8, 64'h0);
      send_full(4'hB, 4'h0, 4'h9, 4'hA, 64'h0);
      total++;
      if (wr_ptr !== 11'd0) begin
         bad++;
         $display("FAIL exact_fit_ptr got %0d expected 0", wr_ptr);
      end
   endtask

   task automatic test_rst_emit();
      int l;
      bit ok;
      do_reset();
      send(4'h3, 4'h0, 4'hF, 4'h2, 64'h1122334455667788, l, ok);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if (wr_en !== 1'b0 || wr_ptr !== 11'd0 || in_ready !== 1'b1 || sbq.size() != 6) begin
         bad++;
         $display("FAIL rst_emit got en=%b ptr=%0d rdy=%b pending=%0d expected en=0 ptr=0 rdy=1 pending=6",
                  wr_en, wr_ptr, in_ready, sbq.size());
      end
      sbq.delete();
      mptr = 0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_restart();
      do_reset();
      send_full(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
      send_full(4'h1, 4'h0, 4'h0, 4'h0, 64'h0);
      @(negedge clk);
      restart = 1'b1; in_valid = 1'b1; icode = 4'h1;
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++;
         $display("FAIL restart_ready got %b expected 0", in_ready);
      end
      @(posedge clk); #1;
      restart = 1'b0; in_valid = 1'b0;
      mptr = 0;
      total++;
      if (wr_ptr !== 11'd0 || wr_en !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL restart got ptr=%0d en=%b err=%b expected ptr=0 en=0 err=0", wr_ptr, wr_en, err);
      end
      send_full(4'hA, 4'h0, 4'h3, 4'h5, 64'h0);
      send_full(4'hB, 4'h0, 4'h6, 4'h2, 64'h0);
      send_full(4'h3, 4'h0, 4'h4, 4'h1, 64'h8);
   endtask

   initial begin
      rst = 1'b1; restart = 1'b0; in_valid = 1'b0;
      icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0;
      test_reset();
      test_irmovq();
      test_call_after_nop();
      test_illegal();
      test_overflow();
      test_rst_emit();
      test_restart();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
